fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin write arbiter sharing one 32-bit synchronous FIFO (64 deep, `write`/`wdata`/`full` interface) among N producers. Each producer uses a valid/ready handshake. The arbiter grants one owner at a time, for bursts of up to MAX_BURST beats, and drives the FIFO write port. It never asserts a FIFO write while the FIFO reports full. It sits directly in front of the FIFO's write side; the FIFO read side is untouched.

## Interface
- N, 4: number of requesters (2..8).
- MAX_BURST, 4: maximum consecutive beats per grant (1..16).
- clk  in  1  clock, all state on rising edge.
- nrst  in  1  asynchronous, active-low reset.
- req_valid  in  N  requester i has a beat on req_data[i].
- req_data  in  N*32  requester i data at bits [32*i+31:32*i].
- req_ready  out  N  beat accepted on this edge when valid&ready.
- fifo_full  in  1  FIFO full flag.
- fifo_write  out  1  FIFO write strobe.
- fifo_wdata  out  32  FIFO write data.
- grant_id  out  3  current owner index; 0 when IDLE.
- busy  out  1  high in BUSY state.

## Operation
- States: IDLE (no owner), BUSY (owner held).
- Registers: state, owner, last_served, beat_cnt (5 bits).
- Reset values: state=IDLE, owner=0, last_served=N-1 (so requester 0 wins first), beat_cnt=0.
- Output reset values: req_ready=0, fifo_write=0, grant_id=0, busy=0, fifo_wdata=0.
- Pick: the first i with req_valid[i]=1, searching from (last_served+1) mod N upward with wrap.
- IDLE:
  - If any req_valid is set, latch owner=pick, beat_cnt=0 and go to BUSY.
  - No beat is accepted in IDLE; this gives one bubble cycle per arbitration from IDLE.
- BUSY, combinational outputs:
  - req_ready[owner] = !fifo_full; all other req_ready bits are 0.
  - fifo_write = req_valid[owner] & !fifo_full.
  - fifo_wdata = req_data slice of owner. It is a don't-care when fifo_write=0, but it is driven from owner and must not be X.
- Beat: fifo_write=1 on an edge. Then beat_cnt increments.
- Release conditions, evaluated each BUSY edge:
  - (a) beat occurs and beat_cnt+1 == MAX_BURST, or
  - (b) req_valid[owner]=0.
- On release:
  - last_served=owner.
  - If another requester (pick excluding owner) is valid, switch owner to it with beat_cnt=0 and stay in BUSY, with no bubble.
  - If only the old owner is valid, re-grant it; this applies under (a) only.
  - Otherwise go to IDLE.
- fifo_full in BUSY stalls the owner. The stall does not count toward MAX_BURST and does not release the grant.
- A drop of valid during a full stall releases per (b).
- fifo_write is never asserted while fifo_full=1. The FIFO does not protect itself against writes when full.
- Reset asserted mid-burst: all outputs go to their reset values immediately (asynchronously). A partial burst is simply truncated; accepted beats are already in the FIFO.

## Timing
- Single clock domain. FIFO inputs are combinational from registered state plus req_valid/fifo_full, with no registered delay.
- First beat from IDLE: accepted on the 2nd edge after req_valid rises (edge 1 grants, edge 2 writes).
- Handover in BUSY: zero bubble. The new owner's beat can be accepted on the edge after the releasing edge.
- Sustained throughput: 1 beat/cycle while the owner stays valid and the FIFO is not full.
- Fairness: an N-way contention with MAX_BURST=B serves each requester at least B beats every N*B beats.

## Configuration
- FIFO_ARB_STATS_EN defined:
  - Adds input stat_clear (1) and output stat_beats (N*16).
  - stat_beats holds a per-requester count of accepted beats, 16 bits, saturating at 0xFFFF.
  - stat_clear zeroes all counters synchronously, and has priority over a same-cycle increment.
  - Counters reset to 0.
- FIFO_ARB_STATS_EN undefined: those ports and counters are absent, and the block behaviour is otherwise identical.

## Structure
- Package fifo_arb_pkg holds:
  - state enum {IDLE, BUSY};
  - localparams DATA_W=32, ID_W=3, STAT_W=16.
- Sub-module fifo_arb_rr_pick: purely combinational.
  - Inputs: req[N], last[ID_W], exclude_en, exclude_id.
  - Outputs: found, idx.
  - Used for both the IDLE pick and the release pick.

## Test plan
- Reset, then req_valid=4'b0001 with data 0xA0..0xA3 → grant_id=0 after edge 1. Writes 0xA0,0xA1,0xA2,0xA3 on edges 2–5. After edge 5 the grant is re-issued to requester 0 (sole requester).
- All four valid continuously, MAX_BURST=4 → FIFO order is 4 beats from req0, then req1, req2, req3, req0. No bubble between bursts.
- Owner req2 mid-burst, fifo_full held high for 5 cycles → req_ready=0 and fifo_write=0 throughout. The burst resumes after fifo_full falls, and beat_cnt is unchanged across the stall.
- req1 drops valid after 2 beats while req3 is valid → the owner switches to 3 on the next edge and last_served=1. Next contention among {1,3} starts at 2 and therefore picks 3 only if 2 is idle.
- nrst pulsed low mid-burst → fifo_write, req_ready and busy go to 0 within the same cycle. After release, requester 0 wins first.
- FIFO_ARB_STATS_EN: write 10 beats from req0 and 3 from req1 → stat_beats shows 10 and 3. stat_clear for one cycle → all counters read 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ID_W   = 3;
  localparam int STAT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Round-robin picker: finds the first requester after 'last' (with wrap),
// optionally skipping one index. Purely combinational.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  input  logic            exclude_en,
  input  logic [ID_W-1:0] exclude_id,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  // Walk the ring starting one past 'last'; the first eligible requester wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && (j == ((int'(last) + k) % N)) && req[j] &&
            !(exclude_en && (exclude_id == ID_W'(j)))) begin
          found = 1'b1;
          idx   = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter in front of a shared FIFO write port.
// Owners hold the grant for up to MAX_BURST beats; handover between owners
// has no bubble, while a grant from IDLE costs one cycle.
// Optional per-requester beat counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [N-1:0]        req_valid,
  input  logic [N*DATA_W-1:0] req_data,
  output logic [N-1:0]        req_ready,
  input  logic                fifo_full,
  output logic                fifo_write,
  output logic [DATA_W-1:0]   fifo_wdata,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                stat_clear,
  output logic [N*STAT_W-1:0] stat_beats
`endif
);

  arb_state_t        state, state_nxt;
  logic [ID_W-1:0]   owner, owner_nxt;
  logic [ID_W-1:0]   last_served, last_nxt;
  logic [4:0]        beat_cnt, cnt_nxt;

  logic              owner_valid;
  logic [DATA_W-1:0] owner_data;
  logic              beat;
  logic              burst_done;
  logic              release_grant;

  logic              idle_found;
  logic [ID_W-1:0]   idle_idx;
  logic              rel_found;
  logic [ID_W-1:0]   rel_idx;

  // Fresh grant from IDLE: search after the last requester served.
  fifo_arb_rr_pick #(.N(N)) u_idle_pick (
    .req        (req_valid),
    .last       (last_served),
    .exclude_en (1'b0),
    .exclude_id (owner),
    .found      (idle_found),
    .idx        (idle_idx)
  );

  // Handover on release: search after the current owner, skipping it.
  fifo_arb_rr_pick #(.N(N)) u_rel_pick (
    .req        (req_valid),
    .last       (owner),
    .exclude_en (1'b1),
    .exclude_id (owner),
    .found      (rel_found),
    .idx        (rel_idx)
  );

  // Select the current owner's valid bit and data slice.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == ID_W'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign beat          = (state == BUSY) && owner_valid && !fifo_full;
  assign burst_done    = beat && ((beat_cnt + 5'd1) == 5'(MAX_BURST));
  assign release_grant = (state == BUSY) && (burst_done || !owner_valid);

  // Arbitration state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      owner       <= '0;
      last_served <= ID_W'(N - 1);
      beat_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_served <= last_nxt;
      beat_cnt    <= cnt_nxt;
    end
  end

  // Next-state: grant from IDLE, count beats, release and hand over in BUSY.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_served;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (idle_found) begin
          state_nxt = BUSY;
          owner_nxt = idle_idx;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (release_grant) begin
          last_nxt = owner;
          cnt_nxt  = '0;
          if (rel_found) begin
            owner_nxt = rel_idx;
          end else if (!burst_done) begin
            // Owner went invalid and nobody else wants the FIFO.
            state_nxt = IDLE;
          end
          // Otherwise a finished burst with a sole requester re-grants it.
        end else if (beat) begin
          cnt_nxt = beat_cnt + 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO write port and handshake outputs, driven only while an owner is held.
  always_comb begin
    req_ready  = '0;
    fifo_write = 1'b0;
    fifo_wdata = '0;
    grant_id   = '0;
    busy       = 1'b0;
    if (state == BUSY) begin
      busy       = 1'b1;
      grant_id   = owner;
      fifo_write = owner_valid && !fifo_full;
      fifo_wdata = owner_data;
      for (int i = 0; i < N; i++) begin
        if (owner == ID_W'(i)) begin
          req_ready[i] = !fifo_full;
        end
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [N];

  // Per-requester saturating beat counters; clear wins over a same-cycle beat.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < N; i++) stat_cnt[i] <= '0;
    end else if (stat_clear) begin
      for (int i = 0; i < N; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (beat && (owner == ID_W'(i)) && (stat_cnt[i] != '1)) begin
          stat_cnt[i] <= stat_cnt[i] + STAT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_stat_out
    assign stat_beats[STAT_W*g +: STAT_W] = stat_cnt[g];
  end
`endif

endmodule
